// File: rtl/tri_vertex_fetch_sched.sv
// tri_vertex_fetch_sched
//   Sequencer between the coordinate ROM and the line rasterizer. A start
//   command fetches one primitive's vertex words from the ROM, one word per
//   cycle. It then issues the primitive's edges as line commands over a
//   valid/ready handshake: three edges for a triangle, one for a line.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             primitive request, sampled only while idle
//   mode              0 = triangle (6 words, 3 edges), 1 = line (4 words, 1 edge)
//   base_addr         ROM address of x0, sampled with start
//   busy, done        busy from the cycle after start through the done cycle;
//                     done is a one-cycle pulse
//   rom_addr/rom_data combinational ROM read port, owned while fetching
//   line_valid/ready  edge command handshake
//   line_x0..line_y1  edge endpoints; line_idx is the edge number within the primitive
//   clip_flag         a word of the current primitive saturated
module tri_vertex_fetch_sched #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COORD_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]  rom_data,
  output logic                   line_valid,
  input  logic                   line_ready,
  output logic [COORD_WIDTH-1:0] line_x0,
  output logic [COORD_WIDTH-1:0] line_y0,
  output logic [COORD_WIDTH-1:0] line_x1,
  output logic [COORD_WIDTH-1:0] line_y1,
  output logic [1:0]             line_idx,
  output logic                   clip_flag
);

  typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDone} state_e;

  state_e r_state;
  state_e w_state_next;

  logic                   r_mode;
  logic [2:0]             r_fetch_cnt;
  logic [1:0]             r_edge_cnt;
  logic [ADDR_WIDTH-1:0]  r_rom_addr;
  logic [COORD_WIDTH-1:0] r_word [6];
  logic                   r_clip;
  logic                   r_valid;
  logic [COORD_WIDTH-1:0] r_x0, r_y0, r_x1, r_y1;
  logic [1:0]             r_idx;

  logic                   w_fetch_last;
  logic                   w_edge_last;
  logic                   w_accept;
  logic                   w_sat;
  logic [COORD_WIDTH-1:0] w_capture;
  logic                   w_load_edge;
  logic [1:0]             w_edge_sel;
  logic [1:0]             w_va, w_vb;

  assign w_fetch_last = (r_fetch_cnt == (r_mode ? 3'd3 : 3'd5));
  assign w_edge_last  = (r_edge_cnt == (r_mode ? 2'd0 : 2'd2));
  assign w_accept     = r_valid && line_ready;

  // Any bit above the coordinate field means the word is out of range.
  assign w_sat     = |(rom_data >> COORD_WIDTH);
  assign w_capture = w_sat ? {COORD_WIDTH{1'b1}} : rom_data[COORD_WIDTH-1:0];

  // The first EMIT cycle (valid still low) loads edge 0; every accepted
  // non-final edge loads the next one so valid never drops between edges.
  assign w_load_edge = !r_valid || (line_ready && !w_edge_last);
  assign w_edge_sel  = r_valid ? (r_edge_cnt + 2'd1) : 2'd0;
  assign w_va        = w_edge_sel;
  assign w_vb        = (w_edge_sel == 2'd2) ? 2'd0 : (w_edge_sel + 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_next = StFetch;
      StFetch: if (w_fetch_last) w_state_next = StEmit;
      StEmit:  if (w_accept && w_edge_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode      <= 1'b0;
      r_fetch_cnt <= 3'd0;
      r_edge_cnt  <= 2'd0;
      r_rom_addr  <= '0;
      r_clip      <= 1'b0;
      r_valid     <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_idx       <= 2'd0;
      for (int i = 0; i < 6; i++) begin
        r_word[i] <= '0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mode      <= mode;
            r_rom_addr  <= base_addr;
            r_fetch_cnt <= 3'd0;
            r_edge_cnt  <= 2'd0;
            r_clip      <= 1'b0;
          end
        end
        StFetch: begin
          r_word[r_fetch_cnt] <= w_capture;
          if (w_sat) r_clip <= 1'b1;
          // The address register tracks base + fetch_cnt and wraps naturally.
          if (!w_fetch_last) begin
            r_fetch_cnt <= r_fetch_cnt + 3'd1;
            r_rom_addr  <= r_rom_addr + ADDR_WIDTH'(1);
          end else begin
            r_edge_cnt <= 2'd0;
          end
        end
        StEmit: begin
          if (w_load_edge) begin
            r_valid    <= 1'b1;
            r_edge_cnt <= w_edge_sel;
            r_idx      <= w_edge_sel;
            r_x0       <= r_word[{w_va, 1'b0}];
            r_y0       <= r_word[{w_va, 1'b1}];
            r_x1       <= r_word[{w_vb, 1'b0}];
            r_y1       <= r_word[{w_vb, 1'b1}];
          end else if (w_accept) begin
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != StIdle);
  assign done       = (r_state == StDone);
  assign rom_addr   = r_rom_addr;
  assign line_valid = r_valid;
  assign line_x0    = r_x0;
  assign line_y0    = r_y0;
  assign line_x1    = r_x1;
  assign line_y1    = r_y1;
  assign line_idx   = r_idx;
  assign clip_flag  = r_clip;

endmodule
